// File: rtl/car_cruise_ctrl.sv
// car_cruise_ctrl: traffic-light driven cruise controller.
// A four-state Moore FSM (PARKED, ACCEL, CRUISE, BRAKING) with a speed
// register and a dwell counter that parks the car after it has been standing
// still in BRAKING for PARK_DELAY consecutive non-green cycles.
module car_cruise_ctrl #(
  parameter int SPEED_W     = 4,
  parameter int MAX_SPEED   = 15,
  parameter int ACCEL_STEP  = 1,
  parameter int BRAKE_STEP  = 2,
  parameter int PARK_DELAY  = 4,
  parameter int YELLOW_MODE = 0,
  parameter int GO_THRESH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         trafficlight,
  output logic               gas,
  output logic               brakes,
  output logic               park,
  output logic [SPEED_W-1:0] speed,
  output logic               moving
);

  localparam int DW = $clog2(PARK_DELAY + 1);

  // Arithmetic is done one bit wider than the speed register so that
  // acceleration saturates instead of wrapping.
  localparam logic [SPEED_W:0]   MAX_X      = (SPEED_W + 1)'(MAX_SPEED);
  localparam logic [SPEED_W:0]   ACCEL_X    = (SPEED_W + 1)'(ACCEL_STEP);
  localparam logic [SPEED_W:0]   BRAKE_X    = (SPEED_W + 1)'(BRAKE_STEP);
  localparam logic [SPEED_W:0]   GO_X       = (SPEED_W + 1)'(GO_THRESH);
  localparam logic [SPEED_W-1:0] BRAKE_S    = SPEED_W'(BRAKE_STEP);
  localparam logic [DW-1:0]      DWELL_LAST = DW'(PARK_DELAY - 1);

  typedef enum logic [1:0] {
    PARKED  = 2'd0,
    ACCEL   = 2'd1,
    CRUISE  = 2'd2,
    BRAKING = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [SPEED_W-1:0]   speed_next;
  logic [DW-1:0]        dwell, dwell_next;
  logic                 go;
  logic [SPEED_W:0]     speed_x;
  logic [SPEED_W:0]     accel_sum;
  logic [SPEED_W:0]     accel_sat;
  logic [SPEED_W-1:0]   brake_sat;

  // Light decode: green, or yellow run when enabled and fast enough, means go;
  // red, invalid (11) and every other yellow are a stop request.
  always_comb begin
    speed_x = {1'b0, speed};
    go      = 1'b0;
    case (trafficlight)
      2'b00:   go = 1'b1;
      2'b01:   go = (YELLOW_MODE != 0) && (speed_x >= GO_X);
      default: go = 1'b0;
    endcase
  end

  // Saturating speed arithmetic for the ACCEL and BRAKING states.
  always_comb begin
    accel_sum = speed_x + ACCEL_X;
    accel_sat = (accel_sum > MAX_X) ? MAX_X : accel_sum;
    brake_sat = (speed_x >= BRAKE_X) ? (speed - BRAKE_S) : '0;
  end

  // Next-state, next-speed and dwell counter decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    speed_next = speed;
    dwell_next = '0;
    case (state)
      PARKED: begin
        speed_next = '0;
        if (go) state_next = ACCEL;
      end
      ACCEL: begin
        if (!go) begin
          state_next = BRAKING;
        end else begin
          speed_next = accel_sat[SPEED_W-1:0];
          if (accel_sat == MAX_X) state_next = CRUISE;
        end
      end
      CRUISE: begin
        if (!go) state_next = BRAKING;
      end
      BRAKING: begin
        if (go) begin
          state_next = ACCEL;
        end else if (speed != '0) begin
          speed_next = brake_sat;
        end else if (dwell == DWELL_LAST) begin
          state_next = PARKED;
        end else begin
          dwell_next = dwell + DW'(1);
        end
      end
      default: state_next = PARKED;
    endcase
  end

  // State, speed and dwell registers, all updated on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state <= PARKED;
      speed <= '0;
      dwell <= '0;
    end else begin
      state <= state_next;
      speed <= speed_next;
      dwell <= dwell_next;
    end
  end

  // Moore outputs decoded from the registers only.
  assign gas    = (state == ACCEL);
  assign brakes = (state == BRAKING);
  assign park   = (state == PARKED);
  assign moving = (speed != '0);

endmodule

// File: tb/tb_car_cruise_ctrl.sv
// Bench for car_cruise_ctrl: directed scenarios on a default instance (dut0)
// and a YELLOW_MODE=1 instance (dut1), then randomized light/reset sequences
// checked every cycle against a behavioural model of the driving rules.
module tb_car_cruise_ctrl;

  logic       clk = 1'b0;
  logic       rst   [2];
  logic [1:0] light [2];
  logic       gas [2], brakes [2], park [2], moving [2];
  logic [3:0] speed [2];

  int vectors = 0;
  int errs    = 0;

  // Behavioural model: one entry per instance.
  localparam int M_PARK = 0, M_ACCEL = 1, M_CRUISE = 2, M_BRAKE = 3;
  int m_mode [2];
  int m_speed [2];
  int m_still [2];   // consecutive stopped non-green cycles while braking

  car_cruise_ctrl dut0 (
    .clk(clk), .reset(rst[0]), .trafficlight(light[0]),
    .gas(gas[0]), .brakes(brakes[0]), .park(park[0]),
    .speed(speed[0]), .moving(moving[0])
  );

  car_cruise_ctrl #(.YELLOW_MODE(1)) dut1 (
    .clk(clk), .reset(rst[1]), .trafficlight(light[1]),
    .gas(gas[1]), .brakes(brakes[1]), .park(park[1]),
    .speed(speed[1]), .moving(moving[1])
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Observed outputs packed as {gas, brakes, park, moving, speed}.
  function automatic logic [7:0] obs(int i);
    return {gas[i], brakes[i], park[i], moving[i], speed[i]};
  endfunction

  // Expected packed outputs for a given gas/brakes/park and speed.
  function automatic logic [7:0] ev(bit g, bit b, bit p, int s);
    return {g, b, p, (s != 0), 4'(s)};
  endfunction

  function automatic logic [7:0] model_out(int i);
    return ev(m_mode[i] == M_ACCEL, m_mode[i] == M_BRAKE,
              m_mode[i] == M_PARK, m_speed[i]);
  endfunction

  task automatic report(string name, int i, logic [7:0] want);
    errs++;
    $display("FAIL %s dut%0d got=%b want=%b (gas,brakes,park,moving,speed[3:0])",
             name, i, obs(i), want);
  endtask

  // Apply one clock edge under the driving rules to model instance i.
  task automatic model_edge(int i);
    bit green;
    int still;
    if (rst[i]) begin
      m_mode[i] = M_PARK; m_speed[i] = 0; m_still[i] = 0;
      return;
    end
    green = (light[i] == 2'b00) ||
            (light[i] == 2'b01 && i == 1 && m_speed[i] >= 8);
    still = 0;
    case (m_mode[i])
      M_PARK:   if (green) m_mode[i] = M_ACCEL;
      M_ACCEL:  if (!green) m_mode[i] = M_BRAKE;
                else begin
                  m_speed[i] = (m_speed[i] + 1 > 15) ? 15 : m_speed[i] + 1;
                  if (m_speed[i] == 15) m_mode[i] = M_CRUISE;
                end
      M_CRUISE: if (!green) m_mode[i] = M_BRAKE;
      default: begin
        if (green) m_mode[i] = M_ACCEL;
        else if (m_speed[i] > 0) m_speed[i] = (m_speed[i] >= 2) ? m_speed[i] - 2 : 0;
        else if (m_still[i] + 1 >= 4) m_mode[i] = M_PARK;
        else still = m_still[i] + 1;
      end
    endcase
    m_still[i] = still;
  endtask

  // One rising edge for both instances; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] want;
    rst[0] = 1'b1; rst[1] = 1'b1; light[0] = 2'b10; light[1] = 2'b10;
    step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    want = ev(0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      vectors++; if (obs(i) !== want) report("reset", i, want);
    end
  endtask

  task automatic test_launch();
    logic [7:0] want;
    light[0] = 2'b00;
    step();
    want = ev(1, 0, 0, 0); vectors++; if (obs(0) !== want) report("launch_e1", 0, want);
    for (int k = 1; k <= 15; k++) begin
      step();
      want = ev(k < 15, 0, 0, k); vectors++;
      if (obs(0) !== want) report($sformatf("launch_speed%0d", k), 0, want);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      want = ev(0, 0, 0, 15); vectors++; if (obs(0) !== want) report("cruise_hold", 0, want);
    end
  endtask

  task automatic test_stop();
    logic [7:0] want;
    int seq [8] = '{13, 11, 9, 7, 5, 3, 1, 0};
    light[0] = 2'b10;
    step();
    want = ev(0, 1, 0, 15); vectors++; if (obs(0) !== want) report("stop_e1", 0, want);
    foreach (seq[k]) begin
      step();
      want = ev(0, 1, 0, seq[k]); vectors++;
      if (obs(0) !== want) report($sformatf("stop_speed%0d", seq[k]), 0, want);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      want = ev(0, k < 4, k == 4, 0); vectors++;
      if (obs(0) !== want) report($sformatf("stop_dwell%0d", k), 0, want);
    end
  endtask

  task automatic test_yellow_mode();
    logic [7:0] want;
    light[1] = 2'b00;
    repeat (11) step();
    want = ev(1, 0, 0, 10); vectors++; if (obs(1) !== want) report("ymode_at10", 1, want);
    light[1] = 2'b01;
    step();
    want = ev(1, 0, 0, 11); vectors++; if (obs(1) !== want) report("ymode_run11", 1, want);
    step();
    want = ev(1, 0, 0, 12); vectors++; if (obs(1) !== want) report("ymode_run12", 1, want);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0; light[1] = 2'b00;
    want = ev(0, 0, 1, 0); vectors++; if (obs(1) !== want) report("ymode_reset", 1, want);
    repeat (6) step();
    want = ev(1, 0, 0, 5); vectors++; if (obs(1) !== want) report("ymode_at5", 1, want);
    light[1] = 2'b01;
    step();
    want = ev(0, 1, 0, 5); vectors++; if (obs(1) !== want) report("ymode_stop5", 1, want);
    step();
    want = ev(0, 1, 0, 3); vectors++; if (obs(1) !== want) report("ymode_brake3", 1, want);
    light[1] = 2'b10;
  endtask

  task automatic test_resume();
    logic [7:0] want;
    light[0] = 2'b00;
    repeat (12) step();
    want = ev(1, 0, 0, 11); vectors++; if (obs(0) !== want) report("resume_at11", 0, want);
    light[0] = 2'b01;   // yellow always stops in the default mode
    step();
    want = ev(0, 1, 0, 11); vectors++; if (obs(0) !== want) report("yellow_stop", 0, want);
    repeat (2) step();
    want = ev(0, 1, 0, 7); vectors++; if (obs(0) !== want) report("resume_brake7", 0, want);
    light[0] = 2'b00;
    step();
    want = ev(1, 0, 0, 7); vectors++; if (obs(0) !== want) report("resume_accel7", 0, want);
    step();
    want = ev(1, 0, 0, 8); vectors++; if (obs(0) !== want) report("resume_accel8", 0, want);
    light[0] = 2'b11;   // invalid light behaves as red
    step();
    want = ev(0, 1, 0, 8); vectors++; if (obs(0) !== want) report("invalid_stop", 0, want);
    repeat (6) step();  // 6,4,2,0 then two stopped cycles
    want = ev(0, 1, 0, 0); vectors++; if (obs(0) !== want) report("dwell2", 0, want);
    light[0] = 2'b00;
    step();
    want = ev(1, 0, 0, 0); vectors++; if (obs(0) !== want) report("dwell_green", 0, want);
    light[0] = 2'b11;
    step();
    want = ev(0, 1, 0, 0); vectors++; if (obs(0) !== want) report("rebrake0", 0, want);
    for (int k = 1; k <= 4; k++) begin
      step();
      want = ev(0, k < 4, k == 4, 0); vectors++;
      if (obs(0) !== want) report($sformatf("repark%0d", k), 0, want);
    end
  endtask

  task automatic test_midrun_reset();
    logic [7:0] want;
    light[0] = 2'b00;
    repeat (12) step();
    light[0] = 2'b10;
    repeat (2) step();
    want = ev(0, 1, 0, 9); vectors++; if (obs(0) !== want) report("mid_brake9", 0, want);
    rst[0] = 1'b1; light[0] = 2'b00;
    step();
    rst[0] = 1'b0;
    want = ev(0, 0, 1, 0); vectors++; if (obs(0) !== want) report("mid_reset", 0, want);
    step();
    want = ev(1, 0, 0, 0); vectors++; if (obs(0) !== want) report("mid_relaunch", 0, want);
    step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    want = ev(0, 0, 1, 0); vectors++; if (obs(0) !== want) report("accel_reset", 0, want);
  endtask

  task automatic test_random();
    logic [7:0] want;
    rst[0] = 1'b1; rst[1] = 1'b1;
    step();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: light[i] = 2'b00;
            5, 6:          light[i] = 2'b01;
            7, 8:          light[i] = 2'b10;
            default:       light[i] = 2'b11;
          endcase
        end
      end
      step();
      for (int i = 0; i < 2; i++) begin
        want = model_out(i); vectors++;
        if (obs(i) !== want) report($sformatf("random_cycle%0d", n), i, want);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; light[i] = 2'b10;
      m_mode[i] = M_PARK; m_speed[i] = 0; m_still[i] = 0;
    end
    test_reset();
    test_launch();
    test_stop();
    test_yellow_mode();
    test_resume();
    test_midrun_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
